// File: rtl/packet_slot_buffer.sv
// packet_slot_buffer: circular FIFO of packet slots. Each slot has its own
// byte-masked word memory and a stored packet size. The writer fills the
// write slot and commits it with packet_send_i; the reader reads the read
// slot and releases it with packet_ack_i.
// Ports:
//   clk_i, reset_i (async, active-high)
//   read side : packet_avail_o, packet_ack_i, packet_rvalid_i, packet_raddr_i,
//               packet_rdata_v_o, packet_rdata_o, packet_rsize_o
//   write side: packet_req_o, packet_send_i, packet_wsize_valid_i,
//               packet_wsize_i, packet_wvalid_i, packet_waddr_i,
//               packet_wdata_i, packet_wdata_size_i
//   status    : occupancy_o, drop_count_o, misalign_err_o
module packet_slot_buffer #(
  parameter int unsigned slot_p       = 4,
  parameter int unsigned data_width_p = 64,
  parameter int unsigned els_p        = 2048
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  output logic                                        packet_avail_o,
  input  logic                                        packet_ack_i,
  input  logic                                        packet_rvalid_i,
  input  logic [$clog2(els_p)-1:0]                    packet_raddr_i,
  output logic                                        packet_rdata_v_o,
  output logic [data_width_p-1:0]                     packet_rdata_o,
  output logic [$clog2(els_p+1)-1:0]                  packet_rsize_o,
  output logic                                        packet_req_o,
  input  logic                                        packet_send_i,
  input  logic                                        packet_wsize_valid_i,
  input  logic [$clog2(els_p+1)-1:0]                  packet_wsize_i,
  input  logic                                        packet_wvalid_i,
  input  logic [$clog2(els_p)-1:0]                    packet_waddr_i,
  input  logic [data_width_p-1:0]                     packet_wdata_i,
  input  logic [$clog2($clog2(data_width_p/8)+1)-1:0] packet_wdata_size_i,
  output logic [$clog2(slot_p+1)-1:0]                 occupancy_o,
  output logic [15:0]                                 drop_count_o,
  output logic                                        misalign_err_o
);

  localparam int unsigned NB    = data_width_p / 8;
  localparam int unsigned LB    = $clog2(NB);
  localparam int unsigned AW    = $clog2(els_p);
  localparam int unsigned SW    = $clog2(els_p + 1);
  localparam int unsigned OW    = $clog2(slot_p + 1);
  localparam int unsigned PW    = $clog2(slot_p);
  localparam int unsigned WORDS = els_p / NB;
  localparam int unsigned WAW   = AW - LB;

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic [15:0]             drop_q, drop_d;
  logic                    err_q, err_d;
  logic                    rdata_v_q, rdata_v_d;
  logic [data_width_p-1:0] rdata_q, rdata_d;
  logic [SW-1:0]           size_q [slot_p];
  logic [SW-1:0]           size_d [slot_p];

  logic [31:0]             w_bytes, w_lane;
  logic [NB-1:0]           w_mask;
  logic                    w_mis, r_mis, wr_en, rd_en, commit, free;
  logic [WAW-1:0]          w_word, r_word;
  logic [SW-1:0]           wsize_sat;
  logic [data_width_p-1:0] slot_rword [slot_p];

  // Flow-control flags come straight from the registered occupancy.
  assign packet_avail_o   = (occ_q != '0);
  assign packet_req_o     = (occ_q != OW'(slot_p));
  assign packet_rdata_v_o = rdata_v_q;
  assign packet_rdata_o   = rdata_q;
  assign packet_rsize_o   = size_q[rd_ptr_q];
  assign occupancy_o      = occ_q;
  assign drop_count_o     = drop_q;
  assign misalign_err_o   = err_q;

  // Access decode: byte mask, word index and alignment checks.
  always_comb begin
    w_bytes = 32'd1 << packet_wdata_size_i;
    w_lane  = 32'(packet_waddr_i[LB-1:0]);
    w_mis   = (32'(packet_wdata_size_i) > LB) ||
              ((32'(packet_waddr_i) & (w_bytes - 32'd1)) != 32'd0);
    for (int b = 0; b < NB; b++) begin
      w_mask[b] = (32'(b) >= w_lane) && (32'(b) < (w_lane + w_bytes));
    end
    w_word    = packet_waddr_i[AW-1:LB];
    r_word    = packet_raddr_i[AW-1:LB];
    r_mis     = (packet_raddr_i[LB-1:0] != '0);
    wr_en     = packet_wvalid_i && packet_req_o && !w_mis;
    rd_en     = packet_rvalid_i && packet_avail_o && !r_mis;
    commit    = packet_send_i && packet_req_o;
    free      = packet_ack_i && packet_avail_o;
    wsize_sat = (packet_wsize_i > SW'(els_p)) ? SW'(els_p) : packet_wsize_i;
  end

  // Per-slot word memory. Write slot and read slot are always distinct
  // whenever both accesses are legal, so each memory sees at most one access.
  for (genvar s = 0; s < slot_p; s++) begin : g_slot
    logic [data_width_p-1:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
      if (wr_en && (wr_ptr_q == PW'(s))) begin
        for (int b = 0; b < NB; b++) begin
          if (w_mask[b]) mem[w_word][b*8 +: 8] <= packet_wdata_i[b*8 +: 8];
        end
      end
    end

    assign slot_rword[s] = mem[r_word];
  end

  // Next-state for pointers, occupancy, counters, read port and sizes.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    drop_d    = drop_q;
    err_d     = err_q;
    rdata_v_d = rd_en;
    rdata_d   = rdata_q;
    size_d    = size_q;

    if (commit) wr_ptr_d = wr_ptr_q + PW'(1);
    if (free)   rd_ptr_d = rd_ptr_q + PW'(1);
    if (commit && !free)      occ_d = occ_q + OW'(1);
    else if (!commit && free) occ_d = occ_q - OW'(1);

    // A refused commit counts even when a free happens in the same cycle.
    if (packet_send_i && !packet_req_o && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

    if ((packet_wvalid_i && w_mis) || (packet_rvalid_i && r_mis)) err_d = 1'b1;

    if (rd_en) rdata_d = slot_rword[rd_ptr_q];

    if (free) size_d[rd_ptr_q] = '0;
    if (packet_wsize_valid_i && packet_req_o) size_d[wr_ptr_q] = wsize_sat;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      drop_q    <= '0;
      err_q     <= 1'b0;
      rdata_v_q <= 1'b0;
      rdata_q   <= '0;
      size_q    <= '{default: '0};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
      rdata_v_q <= rdata_v_d;
      rdata_q   <= rdata_d;
      size_q    <= size_d;
    end
  end

endmodule

// File: tb/tb_packet_slot_buffer.sv
// Testbench for packet_slot_buffer: a 64-bit instance checked every cycle
// against a byte-level slot model, plus a 128-bit instance with directed checks.
module tb_packet_slot_buffer;

  localparam int NS  = 4;
  localparam int NB  = 8;
  localparam int ELS = 2048;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-bit instance signals
  logic        avail, ack, rvalid, rdata_v, req, send, wsize_valid, wvalid, err;
  logic [10:0] raddr, waddr;
  logic [63:0] rdata, wdata;
  logic [11:0] rsize, wsize;
  logic [1:0]  wdsz;
  logic [2:0]  occ;
  logic [15:0] drop;

  // 128-bit instance signals
  logic         b_avail, b_ack, b_rvalid, b_rdata_v, b_req, b_send, b_wsize_valid, b_wvalid, b_err;
  logic [10:0]  b_raddr, b_waddr;
  logic [127:0] b_rdata, b_wdata;
  logic [11:0]  b_rsize, b_wsize;
  logic [2:0]   b_wdsz;
  logic [2:0]   b_occ;
  logic [15:0]  b_drop;

  packet_slot_buffer #(.slot_p(4), .data_width_p(64), .els_p(2048)) dut (
    .clk_i(clk), .reset_i(rst),
    .packet_avail_o(avail), .packet_ack_i(ack), .packet_rvalid_i(rvalid),
    .packet_raddr_i(raddr), .packet_rdata_v_o(rdata_v), .packet_rdata_o(rdata),
    .packet_rsize_o(rsize), .packet_req_o(req), .packet_send_i(send),
    .packet_wsize_valid_i(wsize_valid), .packet_wsize_i(wsize),
    .packet_wvalid_i(wvalid), .packet_waddr_i(waddr), .packet_wdata_i(wdata),
    .packet_wdata_size_i(wdsz), .occupancy_o(occ), .drop_count_o(drop),
    .misalign_err_o(err)
  );

  packet_slot_buffer #(.slot_p(4), .data_width_p(128), .els_p(2048)) dut128 (
    .clk_i(clk), .reset_i(rst),
    .packet_avail_o(b_avail), .packet_ack_i(b_ack), .packet_rvalid_i(b_rvalid),
    .packet_raddr_i(b_raddr), .packet_rdata_v_o(b_rdata_v), .packet_rdata_o(b_rdata),
    .packet_rsize_o(b_rsize), .packet_req_o(b_req), .packet_send_i(b_send),
    .packet_wsize_valid_i(b_wsize_valid), .packet_wsize_i(b_wsize),
    .packet_wvalid_i(b_wvalid), .packet_waddr_i(b_waddr), .packet_wdata_i(b_wdata),
    .packet_wdata_size_i(b_wdsz), .occupancy_o(b_occ), .drop_count_o(b_drop),
    .misalign_err_o(b_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: slots as byte arrays plus FIFO bookkeeping.
  logic [7:0]  m_mem [NS][ELS];
  int          m_size [NS];
  int          m_occ, m_wr, m_rd, m_drop;
  bit          m_err, m_rv;
  logic [63:0] m_rdata;

  task automatic model_reset();
    m_occ = 0; m_wr = 0; m_rd = 0; m_drop = 0;
    m_err = 0; m_rv = 0; m_rdata = '0;
    for (int s = 0; s < NS; s++) m_size[s] = 0;
  endtask

  // Applies the current inputs to the model, yielding the post-edge state.
  task automatic model_step();
    bit mreq, mavail, commit, fr;
    int n, a, lane;
    mreq   = (m_occ != NS);
    mavail = (m_occ != 0);
    commit = send && mreq;
    fr     = ack && mavail;
    m_rv   = 0;
    if (wvalid) begin
      n = 1 << wdsz;
      a = int'(waddr);
      if (n > NB || (a % n) != 0) m_err = 1;
      else if (mreq) begin
        lane = a % NB;
        for (int b = 0; b < n; b++) m_mem[m_wr][a + b] = wdata[(lane + b)*8 +: 8];
      end
    end
    if (rvalid) begin
      a = int'(raddr);
      if ((a % NB) != 0) m_err = 1;
      else if (mavail) begin
        m_rv = 1;
        for (int b = 0; b < NB; b++) m_rdata[b*8 +: 8] = m_mem[m_rd][a + b];
      end
    end
    if (send && !mreq && m_drop < 65535) m_drop++;
    if (fr) m_size[m_rd] = 0;
    if (wsize_valid && mreq) m_size[m_wr] = (int'(wsize) > ELS) ? ELS : int'(wsize);
    if (commit) m_wr = (m_wr + 1) % NS;
    if (fr)     m_rd = (m_rd + 1) % NS;
    m_occ = m_occ + int'(commit) - int'(fr);
  endtask

  task automatic check_all();
    check_eq("occupancy", occ, m_occ);
    check_eq("avail", avail, m_occ != 0);
    check_eq("req", req, m_occ != NS);
    check_eq("rdata_v", rdata_v, m_rv);
    check_eq("rdata", rdata, m_rdata);
    check_eq("rsize", rsize, m_size[m_rd]);
    check_eq("drop_count", drop, m_drop);
    check_eq("misalign_err", err, m_err);
  endtask

  task automatic clear();
    ack = 0; rvalid = 0; raddr = '0; send = 0; wsize_valid = 0; wsize = '0;
    wvalid = 0; waddr = '0; wdata = '0; wdsz = '0;
  endtask

  task automatic b_clear();
    b_ack = 0; b_rvalid = 0; b_raddr = '0; b_send = 0; b_wsize_valid = 0; b_wsize = '0;
    b_wvalid = 0; b_waddr = '0; b_wdata = '0; b_wdsz = '0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    check_all();
    clear();
  endtask

  task automatic b_step();
    @(posedge clk); #1;
    b_clear();
  endtask

  task automatic write_word(input int addr, input logic [63:0] d);
    wvalid = 1; waddr = 11'(addr); wdsz = 2'd3; wdata = d;
  endtask

  task automatic reset_now();
    rst = 1;
    #2;
    check_eq("rst_occupancy", occ, 0);
    check_eq("rst_avail", avail, 0);
    check_eq("rst_req", req, 1);
    check_eq("rst_rdata_v", rdata_v, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_rsize", rsize, 0);
    check_eq("rst_drop", drop, 0);
    check_eq("rst_err", err, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  logic [63:0]  prev_marker, marker;
  logic [127:0] pat;
  int n;

  initial begin
    rst = 1;
    clear();
    b_clear();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check_all();

    // 128-bit instance: wide writes, lane placement, size saturation
    pat = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    b_wvalid = 1; b_waddr = 11'd0;  b_wdsz = 3'd4; b_wdata = pat; b_step();
    b_wvalid = 1; b_waddr = 11'd16; b_wdsz = 3'd4; b_wdata = '0;  b_step();
    b_wvalid = 1; b_waddr = 11'd20; b_wdsz = 3'd2; b_wdata = 128'hDEADBEEF << 32; b_step();
    b_wsize_valid = 1; b_wsize = 12'd4000; b_send = 1; b_step();
    check_eq("w128_occupancy", b_occ, 1);
    check_eq("w128_rsize_sat", b_rsize, 2048);
    b_rvalid = 1; b_raddr = 11'd0; b_step();
    check_eq("w128_rdata_v", b_rdata_v, 1);
    check_eq("w128_word0", b_rdata, pat);
    b_rvalid = 1; b_raddr = 11'd16; b_step();
    check_eq("w128_word1", b_rdata, 128'h00000000_00000000_DEADBEEF_00000000);
    check_eq("w128_err_clear", b_err, 0);
    b_wvalid = 1; b_waddr = 11'd0; b_wdsz = 3'd5; b_wdata = '1; b_step();
    check_eq("w128_err_oversize", b_err, 1);
    b_rvalid = 1; b_raddr = 11'd0; b_step();
    check_eq("w128_oversize_suppressed", b_rdata, pat);

    // Fill every slot word so later reads never see uninitialised memory
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < ELS / NB; w++) begin
        write_word(w * NB, {$urandom, $urandom});
        step();
      end
      send = 1; wsize_valid = 1; wsize = 12'($urandom_range(0, 4095));
      step();
    end
    check_eq("fill_full", occ, 4);
    for (int s = 0; s < NS; s++) begin ack = 1; step(); end

    // Single 8-byte packet round trip
    write_word(0, 64'h1122334455667788);
    wsize_valid = 1; wsize = 12'd8;
    step();
    send = 1; step();
    rvalid = 1; raddr = 11'd0; step();
    check_eq("basic_avail", avail, 1);
    check_eq("basic_rsize", rsize, 8);
    check_eq("basic_rdata_v", rdata_v, 1);
    check_eq("basic_rdata", rdata, 64'h1122334455667788);
    step();
    check_eq("basic_rdata_v_one_cycle", rdata_v, 0);
    check_eq("basic_rdata_hold", rdata, 64'h1122334455667788);
    ack = 1; step();

    // Full buffer, refused send alongside a free
    for (int i = 0; i < NS; i++) begin send = 1; step(); end
    check_eq("full_occupancy", occ, 4);
    check_eq("full_req", req, 0);
    send = 1; ack = 1; step();
    check_eq("drop_count_one", drop, 1);
    check_eq("drop_occupancy", occ, 3);
    check_eq("drop_req", req, 1);

    // One slot occupied, send+ack+read+write every cycle; pointers wrap
    ack = 1; step();
    ack = 1; step();
    prev_marker = '0;
    for (int i = 0; i < 6; i++) begin
      marker = {32'hC0DE0000 + 32'(i), $urandom};
      write_word(0, marker);
      send = 1; ack = 1; rvalid = 1; raddr = 11'd0;
      step();
      check_eq("wrap_occupancy", occ, 1);
      if (i > 0) check_eq("wrap_rdata", rdata, prev_marker);
      prev_marker = marker;
    end
    ack = 1; step();

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      send   = ($urandom_range(0, 3) == 0);
      ack    = ($urandom_range(0, 3) == 0);
      rvalid = ($urandom_range(0, 1) == 1);
      raddr  = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047))
                                           : 11'($urandom_range(0, 255) * 8);
      wvalid = ($urandom_range(0, 9) < 6);
      wdsz   = 2'($urandom_range(0, 3));
      n      = 1 << wdsz;
      waddr  = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047))
                                           : 11'(($urandom_range(0, 2047) / n) * n);
      wdata  = {$urandom, $urandom};
      wsize_valid = ($urandom_range(0, 4) == 0);
      wsize  = 12'($urandom_range(0, 4095));
      step();
    end

    // Byte-lane writes and misalignment after a clean reset
    reset_now();
    write_word(0, 64'h0);
    step();
    wvalid = 1; waddr = 11'd3; wdsz = 2'd0; wdata = 64'hAA << 24; step();
    wvalid = 1; waddr = 11'd6; wdsz = 2'd1; wdata = 64'hBBCC << 48; step();
    send = 1; step();
    rvalid = 1; raddr = 11'd0; step();
    check_eq("lanes_rdata", rdata, 64'hBBCC_0000_AA00_0000);
    check_eq("lanes_err_clear", err, 0);
    send = 1; step();
    wvalid = 1; waddr = 11'd5; wdsz = 2'd1; wdata = 64'hFFFF << 40; step();
    check_eq("misalign_err_set", err, 1);
    rvalid = 1; raddr = 11'd0; step();
    check_eq("misalign_suppressed", rdata, 64'hBBCC_0000_AA00_0000);
    step();
    check_eq("misalign_sticky", err, 1);

    // Reset while a read is in flight with two slots occupied
    check_eq("pre_reset_occupancy", occ, 2);
    rvalid = 1; raddr = 11'd8; step();
    check_eq("pre_reset_rdata_v", rdata_v, 1);
    reset_now();
    step();
    check_eq("post_reset_rdata_v", rdata_v, 0);
    check_eq("post_reset_occupancy", occ, 0);

    // Memory survives reset
    send = 1; step();
    rvalid = 1; raddr = 11'd0; step();
    check_eq("mem_retained", rdata, 64'hBBCC_0000_AA00_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
